// File: rtl/uart_mmio_responder_pkg.sv
// Shared definitions for the UART MMIO responder: I/O offset map, status bit
// positions, TX state encoding and a small zero-extension helper.
package uart_mmio_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OFF_W  = 3;

  localparam logic [OFF_W-1:0] OFF_TXSTAT = 3'd0;
  localparam logic [OFF_W-1:0] OFF_RXSTAT = 3'd1;
  localparam logic [OFF_W-1:0] OFF_TXDATA = 3'd2;
  localparam logic [OFF_W-1:0] OFF_RXDATA = 3'd3;
  localparam logic [OFF_W-1:0] OFF_CYCCNT = 3'd4;
  localparam logic [OFF_W-1:0] OFF_INSCNT = 3'd5;
  localparam logic [OFF_W-1:0] OFF_CNTRST = 3'd6;
  localparam logic [OFF_W-1:0] OFF_RSVD   = 3'd7;

  localparam int unsigned TXSTAT_READY_BIT = 0;
  localparam int unsigned RXSTAT_VALID_BIT = 0;
  localparam int unsigned RXSTAT_OVF_BIT   = 1;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_e;

  function automatic logic [DATA_W-1:0] zext_byte(input logic [BYTE_W-1:0] b);
    return {{(DATA_W-BYTE_W){1'b0}}, b};
  endfunction

endpackage

// File: rtl/uart_mmio_responder_if.sv
// CPU I/O-space bus plus UART ready/valid ports seen by the MMIO responder.
interface uart_mmio_responder_if;
  import uart_mmio_responder_pkg::*;

  logic [DATA_W-1:0] Address;
  logic              WEUART;
  logic              REUART;
  logic [3:0]        ByteSel;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              InstrRetire;
  logic [BYTE_W-1:0] UARTTxData;
  logic              UARTTxValid;
  logic              UARTTxReady;
  logic [BYTE_W-1:0] UARTRxData;
  logic              UARTRxValid;
  logic              UARTRxReady;

  modport master (
    output Address, WEUART, REUART, ByteSel, WriteData, InstrRetire,
           UARTTxReady, UARTRxData, UARTRxValid,
    input  ReadData, UARTTxData, UARTTxValid, UARTRxReady
  );

  modport slave (
    input  Address, WEUART, REUART, ByteSel, WriteData, InstrRetire,
           UARTTxReady, UARTRxData, UARTRxValid,
    output ReadData, UARTTxData, UARTTxValid, UARTRxReady
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO; power-of-two depth so pointers wrap naturally.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full_nxt_c
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             w_push;
  logic             w_pop;

  // Requests against a full/empty FIFO are discarded here.
  assign w_push = i_push && (r_count != CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  assign o_head       = r_mem[r_rptr];
  assign o_empty      = (r_count == '0);
  assign o_full_nxt_c = (w_count_nxt == CW'(DEPTH));
endmodule

// File: rtl/uart_mmio_responder.sv
// MIPS150 I/O-space responder: UART TX holding register, RX FIFO, status
// registers and benchmarking counters behind a registered read port.
module uart_mmio_responder
  import uart_mmio_responder_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_mmio_responder_if.slave  bus
);
  logic [OFF_W-1:0]  w_off;
  logic              w_tx_wr;
  logic              w_cnt_clr;
  logic              w_rx_push;
  logic              w_rx_pop;
  logic              w_ovf_set;
  logic              w_ovf_clr;
  logic              w_rx_empty;
  logic              w_rx_full_nxt;
  logic [BYTE_W-1:0] w_rx_head;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused;

  tx_state_e         r_tx_state;
  logic [BYTE_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic              r_rx_ready;
  logic              r_rx_ovf;
  logic [CNT_W-1:0]  r_cyc;
  logic [CNT_W-1:0]  r_ins;
  logic [DATA_W-1:0] r_rdata;

  assign w_off     = bus.Address[4:2];
  assign w_tx_wr   = bus.WEUART && (w_off == OFF_TXDATA) && bus.ByteSel[0];
  assign w_cnt_clr = bus.WEUART && (w_off == OFF_CNTRST);
  assign w_rx_push = bus.UARTRxValid && r_rx_ready;
  assign w_rx_pop  = bus.REUART && (w_off == OFF_RXDATA);
  assign w_ovf_set = bus.UARTRxValid && !r_rx_ready;
  assign w_ovf_clr = bus.REUART && (w_off == OFF_RXSTAT);
  assign w_unused  = ^{bus.Address[31:5], bus.Address[1:0],
                       bus.WriteData[31:8], bus.ByteSel[3:1]};

  uart_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (BYTE_W)
  ) u_rx_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_rx_push),
    .i_pop        (w_rx_pop),
    .i_data       (bus.UARTRxData),
    .o_head       (w_rx_head),
    .o_empty      (w_rx_empty),
    .o_full_nxt_c (w_rx_full_nxt)
  );

  // TX holding register: a store while BUSY is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_wr) begin
            r_tx_data  <= bus.WriteData[BYTE_W-1:0];
            r_tx_valid <= 1'b1;
            r_tx_state <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (r_tx_valid && bus.UARTTxReady) begin
            r_tx_valid <= 1'b0;
            r_tx_state <= TX_IDLE;
          end
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // Ready tracks the FIFO's next occupancy so it never depends on this cycle's load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_ready <= 1'b0;
      r_rx_ovf   <= 1'b0;
    end else begin
      r_rx_ready <= !w_rx_full_nxt;
      if (w_ovf_set)      r_rx_ovf <= 1'b1;
      else if (w_ovf_clr) r_rx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_cnt_clr) begin
      r_cyc <= '0;
      r_ins <= '0;
    end else begin
      r_cyc <= r_cyc + CNT_W'(1);
      if (bus.InstrRetire) r_ins <= r_ins + CNT_W'(1);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_TXSTAT: w_rdata[TXSTAT_READY_BIT] = (r_tx_state == TX_IDLE);
      OFF_RXSTAT: begin
        w_rdata[RXSTAT_VALID_BIT] = !w_rx_empty;
        w_rdata[RXSTAT_OVF_BIT]   = r_rx_ovf;
      end
      OFF_RXDATA: if (!w_rx_empty) w_rdata = zext_byte(w_rx_head);
      OFF_CYCCNT: w_rdata = DATA_W'(r_cyc);
      OFF_INSCNT: w_rdata = DATA_W'(r_ins);
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)             r_rdata <= '0;
    else if (bus.REUART) r_rdata <= w_rdata;
  end

  assign bus.ReadData    = r_rdata;
  assign bus.UARTTxData  = r_tx_data;
  assign bus.UARTTxValid = r_tx_valid;
  assign bus.UARTRxReady = r_rx_ready;
endmodule

// File: tb/tb_uart_mmio_responder.sv
// Self-checking bench for uart_mmio_responder: register table plus TX, RX,
// counter and reset sequences, with read results checked through a queue.
module tb_uart_mmio_responder;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  uart_mmio_responder_if bus();

  uart_mmio_responder #(.RX_DEPTH(4), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } rd_exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  off;
    logic [31:0] wdata;
    logic [3:0]  bs;
    logic [31:0] exp;
    string       name;
  } vec_t;

  rd_exp_t     sb_q[$];
  logic [7:0]  rx_q[$];
  vec_t        vecs[11];

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endfunction

  task automatic set_addr(input logic [2:0] off);
    bus.Address = {27'd0, off, 2'b00};
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] bs);
    set_addr(off);
    bus.WriteData = d;
    bus.ByteSel   = bs;
    bus.WEUART    = 1'b1;
    @(negedge clk);
    bus.WEUART    = 1'b0;
  endtask

  task automatic check_rd();
    rd_exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got no entry expected one");
    end else begin
      e = sb_q.pop_front();
      chk(e.name, bus.ReadData, e.exp);
    end
  endtask

  task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string name);
    sb_q.push_back('{exp, name});
    set_addr(off);
    bus.REUART = 1'b1;
    @(negedge clk);
    bus.REUART = 1'b0;
    check_rd();
  endtask

  // RXDATA read whose expectation comes from the bench's own byte queue.
  task automatic rd_rx(input string name);
    logic [31:0] e;
    e = 32'd0;
    if (rx_q.size() != 0) e = {24'd0, rx_q.pop_front()};
    rd(3'd3, e, name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.Address     = '0;
    bus.WEUART      = 1'b0;
    bus.REUART      = 1'b0;
    bus.ByteSel     = 4'h0;
    bus.WriteData   = '0;
    bus.InstrRetire = 1'b0;
    bus.UARTTxReady = 1'b0;
    bus.UARTRxData  = 8'h00;
    bus.UARTRxValid = 1'b0;

    vecs[0]  = '{1'b0, 3'd0, 32'h0,        4'h0, 32'h1, "rst_txstat"};
    vecs[1]  = '{1'b0, 3'd1, 32'h0,        4'h0, 32'h0, "rst_rxstat"};
    vecs[2]  = '{1'b0, 3'd2, 32'h0,        4'h0, 32'h0, "rd_txdata_zero"};
    vecs[3]  = '{1'b0, 3'd3, 32'h0,        4'h0, 32'h0, "pop_empty_zero"};
    vecs[4]  = '{1'b0, 3'd5, 32'h0,        4'h0, 32'h0, "rst_inscnt"};
    vecs[5]  = '{1'b0, 3'd6, 32'h0,        4'h0, 32'h0, "rd_cntrst_zero"};
    vecs[6]  = '{1'b0, 3'd7, 32'h0,        4'h0, 32'h0, "rd_rsvd_zero"};
    vecs[7]  = '{1'b1, 3'd7, 32'hFFFFFFFF, 4'hF, 32'h0, "wr_rsvd"};
    vecs[8]  = '{1'b1, 3'd2, 32'h00000099, 4'h2, 32'h0, "wr_tx_lane1"};
    vecs[9]  = '{1'b0, 3'd0, 32'h0,        4'h0, 32'h1, "txstat_after_lane1"};
    vecs[10] = '{1'b0, 3'd1, 32'h0,        4'h0, 32'h0, "rxstat_after_wr"};

    // Reset values observed while rst is held.
    @(negedge clk);
    @(negedge clk);
    chk("rst_txvalid", {31'd0, bus.UARTTxValid}, 32'd0);
    chk("rst_txdata",  {24'd0, bus.UARTTxData},  32'd0);
    chk("rst_rxready", {31'd0, bus.UARTRxReady}, 32'd0);
    chk("rst_readdata", bus.ReadData, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rxready_after_rst", {31'd0, bus.UARTRxReady}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].we) wr(vecs[i].off, vecs[i].wdata, vecs[i].bs);
      else            rd(vecs[i].off, vecs[i].exp, vecs[i].name);
    end
    chk("lane1_no_tx", {31'd0, bus.UARTTxValid}, 32'd0);
    @(negedge clk);
    chk("readdata_hold", bus.ReadData, 32'd0);
    rd(3'd0, 32'h1, "txstat_again");
    @(negedge clk);
    chk("readdata_hold_one", bus.ReadData, 32'h1);

    // TX single byte, held off by ready, with an overrun store mid-way.
    wr(3'd2, 32'hDEAD_BE41, 4'b0001);
    chk("tx_valid_set", {31'd0, bus.UARTTxValid}, 32'd1);
    chk("tx_data_41",   {24'd0, bus.UARTTxData},  32'h41);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) wr(3'd2, 32'h42, 4'b0001);
      else        @(negedge clk);
      chk("tx_hold_data",  {24'd0, bus.UARTTxData},  32'h41);
      chk("tx_hold_valid", {31'd0, bus.UARTTxValid}, 32'd1);
    end
    rd(3'd0, 32'h0, "txstat_busy");
    bus.UARTTxReady = 1'b1;
    chk("tx_hs_data", {24'd0, bus.UARTTxData}, 32'h41);
    @(negedge clk);
    chk("tx_valid_drop", {31'd0, bus.UARTTxValid}, 32'd0);
    rd(3'd0, 32'h1, "txstat_idle");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("tx_no_0x42", {31'd0, bus.UARTTxValid}, 32'd0);
    end
    bus.UARTTxReady = 1'b0;

    // RX fill past depth and overflow.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.UARTRxValid = 1'b1;
      bus.UARTRxData  = 8'h10 + 8'(i);
      chk("rx_ready_fill", {31'd0, bus.UARTRxReady}, (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) rx_q.push_back(8'h10 + 8'(i));
      @(negedge clk);
    end
    bus.UARTRxValid = 1'b0;
    chk("rx_ready_full", {31'd0, bus.UARTRxReady}, 32'd0);
    rd(3'd1, 32'h3, "rxstat_full_ovf");
    for (int i = 0; i < 4; i++) rd_rx("rx_drain");
    chk("rx_ready_drained", {31'd0, bus.UARTRxReady}, 32'd1);
    rd(3'd1, 32'h0, "rxstat_cleared");

    // Push and pop in the same cycle with two entries queued.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bus.UARTRxValid = 1'b1;
      bus.UARTRxData  = 8'hA1 + 8'(i);
      rx_q.push_back(8'hA1 + 8'(i));
      @(negedge clk);
    end
    bus.UARTRxData = 8'h55;
    rx_q.push_back(8'h55);
    sb_q.push_back('{{24'd0, rx_q.pop_front()}, "rx_simul_pop"});
    set_addr(3'd3);
    bus.REUART = 1'b1;
    @(negedge clk);
    bus.REUART      = 1'b0;
    bus.UARTRxValid = 1'b0;
    check_rd();
    rd(3'd1, 32'h1, "rxstat_simul");
    rd_rx("rx_after_simul_a2");
    rd_rx("rx_after_simul_55");
    rd_rx("rx_pop_empty");
    rd(3'd1, 32'h0, "rxstat_empty");

    // Counters: 10 retired instructions over 20 cycles, then clear.
    wr(3'd6, 32'h0, 4'hF);
    for (int i = 0; i < 20; i++) begin
      bus.InstrRetire = (i % 2 == 0);
      @(negedge clk);
    end
    bus.InstrRetire = 1'b0;
    rd(3'd4, 32'd20, "cyccnt_20");
    rd(3'd5, 32'd10, "inscnt_10");
    wr(3'd6, 32'h1234, 4'hF);
    rd(3'd4, 32'd0, "cyccnt_cleared");
    rd(3'd5, 32'd0, "inscnt_cleared");
    rd(3'd4, 32'd2, "cyccnt_elapsed");

    // Reset while BUSY with three bytes buffered.
    wr(3'd2, 32'h77, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      bus.UARTRxValid = 1'b1;
      bus.UARTRxData  = 8'h30 + 8'(i);
      @(negedge clk);
    end
    bus.UARTRxValid = 1'b0;
    chk("busy_before_rst", {31'd0, bus.UARTTxValid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_txvalid", {31'd0, bus.UARTTxValid}, 32'd0);
    rst = 1'b0;
    rd(3'd1, 32'h0, "rst_mid_rxstat");
    rd(3'd0, 32'h1, "rst_mid_txstat");
    rd(3'd3, 32'h0, "rst_mid_rxdata");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
